// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the data memory arbiter.
package data_mem_arbiter_pkg;

   localparam int unsigned DefAddrW = 7;
   localparam int unsigned DefDataW = 32;

   // Sequencer states: arbitrate, drive memory command, acknowledge.
   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAccess = 2'd1,
      StDone   = 2'd2
   } state_e;

   // Port identifiers, also the encoding of the round-robin pointer.
   localparam logic PortCpu = 1'b0;
   localparam logic PortDbg = 1'b1;

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Combinational two-requester round-robin picker.
module data_mem_arbiter_rr_arb2
   import data_mem_arbiter_pkg::*;
(
   input  logic req_cpu,
   input  logic req_dbg,
   input  logic last,
   output logic grant,
   output logic valid
);

   // On a tie the port not named by last wins; otherwise the lone requester.
   always_comb begin
      valid = req_cpu | req_dbg;
      grant = PortCpu;
      if (req_cpu && req_dbg) begin
         grant = (last == PortCpu) ? PortDbg : PortCpu;
      end else if (req_dbg) begin
         grant = PortDbg;
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Data memory sequencer: arbitrates Cpu/Dbg ports, issues one memory command
// per grant, registers read data and pulses a one-cycle acknowledge.
module data_mem_arbiter
   import data_mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = DefAddrW,
   parameter int unsigned DATA_W = DefDataW
) (
   input  logic              clk,
   input  logic              rst_n,
   // Pipeline MEM-stage port
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   output logic              cpu_stall,
   // Debug/loader port
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              dbg_ack,
   // Memory side
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_read_data
);

   state_e state_q, state_d;
   logic   last_q;
   logic   grant_q;
   logic   arb_grant;
   logic   arb_valid;
   logic   grant_edge;

   data_mem_arbiter_rr_arb2 u_rr_arb2 (
      .req_cpu (cpu_req),
      .req_dbg (dbg_req),
      .last    (last_q),
      .grant   (arb_grant),
      .valid   (arb_valid)
   );

   // Arbitration only counts while idle.
   assign grant_edge = (state_q == StIdle) && arb_valid;

   // Next-state logic: IDLE -> ACCESS on any request, then DONE, then IDLE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (arb_valid) state_d = StAccess;
         StAccess: state_d = StDone;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // State register; reset abandons any in-flight access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Round-robin pointer and the port being served, both latched at grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q  <= PortDbg;
         grant_q <= PortCpu;
      end else if (grant_edge) begin
         last_q  <= arb_grant;
         grant_q <= arb_grant;
      end
   end

   // Memory command registers: load at grant, strobe lives for ACCESS only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_address    <= '0;
         mem_write_data <= '0;
         mem_read       <= 1'b0;
         mem_write      <= 1'b0;
      end else if (grant_edge) begin
         if (arb_grant == PortDbg) begin
            mem_address    <= dbg_addr;
            mem_write_data <= dbg_wdata;
            mem_read       <= ~dbg_we;
            mem_write      <= dbg_we;
         end else begin
            mem_address    <= cpu_addr;
            mem_write_data <= cpu_wdata;
            mem_read       <= ~cpu_we;
            mem_write      <= cpu_we;
         end
      end else if (state_q == StAccess) begin
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
      end
   end

   // Read data capture into the served port only, at the end of ACCESS.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpu_rdata <= '0;
         dbg_rdata <= '0;
      end else if ((state_q == StAccess) && mem_read) begin
         if (grant_q == PortDbg) begin
            dbg_rdata <= mem_read_data;
         end else begin
            cpu_rdata <= mem_read_data;
         end
      end
   end

   // Acks decode from DONE so they are one cycle wide and mutually exclusive.
   always_comb begin
      cpu_ack   = (state_q == StDone) && (grant_q == PortCpu);
      dbg_ack   = (state_q == StDone) && (grant_q == PortDbg);
      cpu_stall = cpu_req & ~cpu_ack;
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter with a scoreboard of expected
// memory commands and acknowledges.
module tb_data_mem_arbiter;

   localparam bit CPU = 1'b0;
   localparam bit DBG = 1'b1;

   logic        clk;
   logic        rst_n;
   logic        cpu_req, cpu_we, dbg_req, dbg_we;
   logic [6:0]  cpu_addr, dbg_addr;
   logic [31:0] cpu_wdata, dbg_wdata;
   logic [31:0] cpu_rdata, dbg_rdata;
   logic        cpu_ack, dbg_ack, cpu_stall;
   logic [6:0]  mem_address;
   logic [31:0] mem_write_data, mem_read_data;
   logic        mem_read, mem_write;

   int checks = 0;
   int passed = 0;

   typedef struct {
      bit          port;
      bit          we;
      logic [6:0]  addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } txn_t;

   txn_t cmd_q[$];
   txn_t ack_q[$];
   txn_t mon_t;

   logic [31:0] ref_mem [128];
   logic [31:0] ref_rdata [2];

   // Memory model: preset contents until a location is written.
   logic [31:0] sim_mem [128];
   bit          written [128];

   function automatic logic [31:0] init_word(input logic [6:0] a);
      case (a)
         7'h01:   return 32'h11110001;
         7'h02:   return 32'h22220002;
         7'h05:   return 32'hDEADBEEF;
         default: return 32'hC0DE0000 | {25'd0, a};
      endcase
   endfunction

   assign mem_read_data = written[mem_address] ? sim_mem[mem_address] : init_word(mem_address);

   always @(posedge clk) begin
      if (mem_write) begin
         sim_mem[mem_address] <= mem_write_data;
         written[mem_address] <= 1'b1;
      end
   end

   data_mem_arbiter dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cpu_req        (cpu_req),
      .cpu_we         (cpu_we),
      .cpu_addr       (cpu_addr),
      .cpu_wdata      (cpu_wdata),
      .cpu_rdata      (cpu_rdata),
      .cpu_ack        (cpu_ack),
      .cpu_stall      (cpu_stall),
      .dbg_req        (dbg_req),
      .dbg_we         (dbg_we),
      .dbg_addr       (dbg_addr),
      .dbg_wdata      (dbg_wdata),
      .dbg_rdata      (dbg_rdata),
      .dbg_ack        (dbg_ack),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_read_data  (mem_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Queue the expected command and ack for one access; update the reference.
   function automatic void expect_txn(input bit port, input bit we, input logic [6:0] addr,
                                      input logic [31:0] wdata);
      txn_t t;
      t.port  = port;
      t.we    = we;
      t.addr  = addr;
      t.wdata = wdata;
      t.rdata = we ? ref_rdata[port] : ref_mem[addr];
      if (we) ref_mem[addr] = wdata;
      else    ref_rdata[port] = t.rdata;
      cmd_q.push_back(t);
      ack_q.push_back(t);
   endfunction

   // Scoreboard monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_read || mem_write) begin
            checks++;
            if (mem_read && mem_write) $display("FAIL strobe_excl: both strobes high");
            else passed++;
            checks++;
            if (cmd_q.size() == 0) begin
               $display("FAIL unexpected_cmd: addr %h we %b, none expected", mem_address,
                        mem_write);
            end else begin
               mon_t = cmd_q.pop_front();
               if (mem_write !== mon_t.we || mem_address !== mon_t.addr ||
                   (mon_t.we && mem_write_data !== mon_t.wdata))
                  $display("FAIL cmd: got we %b addr %h wdata %h, want we %b addr %h wdata %h",
                           mem_write, mem_address, mem_write_data, mon_t.we, mon_t.addr,
                           mon_t.wdata);
               else passed++;
            end
         end
         if (cpu_ack || dbg_ack) begin
            checks++;
            if (cpu_ack && dbg_ack) $display("FAIL ack_excl: both acks high");
            else passed++;
            checks++;
            if (ack_q.size() == 0) begin
               $display("FAIL unexpected_ack: cpu %b dbg %b, none expected", cpu_ack, dbg_ack);
            end else begin
               mon_t = ack_q.pop_front();
               if (dbg_ack !== mon_t.port ||
                   (mon_t.port ? dbg_rdata : cpu_rdata) !== mon_t.rdata)
                  $display("FAIL ack: got port %b rdata %h, want port %b rdata %h", dbg_ack,
                           dbg_ack ? dbg_rdata : cpu_rdata, mon_t.port, mon_t.rdata);
               else passed++;
            end
         end
      end
   end

   task automatic drive_port(input bit port, input bit req, input bit we,
                             input logic [6:0] addr, input logic [31:0] wdata);
      if (port == DBG) begin
         dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
      end else begin
         cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      end
   endtask

   // One access on one port; returns cycles to ack and strobe cycles seen.
   task automatic do_access(input bit port, input bit we, input logic [6:0] addr,
                            input logic [31:0] wdata, output int lat, output int strobes);
      bit got = 0;
      @(posedge clk); #1;
      drive_port(port, 1'b1, we, addr, wdata);
      expect_txn(port, we, addr, wdata);
      lat = 0;
      strobes = 0;
      for (int i = 0; i < 12 && !got; i++) begin
         @(negedge clk);
         lat++;
         if (mem_read || mem_write) strobes++;
         if (port == DBG ? dbg_ack : cpu_ack) got = 1;
      end
      drive_port(port, 1'b0, we, addr, wdata);
      checks++;
      if (!got) $display("FAIL access_timeout: port %b got no ack, want ack", port);
      else passed++;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      cmd_q.delete();
      ack_q.delete();
      ref_rdata[0] = '0;
      ref_rdata[1] = '0;
   endtask

   task automatic test_reset();
      apply_reset();
      cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
      #12;
      checks++;
      if ({mem_read, mem_write, cpu_ack, dbg_ack, cpu_stall} !== 5'b0)
         $display("FAIL reset_ctrl: got %b, want 00000",
                  {mem_read, mem_write, cpu_ack, dbg_ack, cpu_stall});
      else passed++;
      checks++;
      if (mem_address !== 7'h0 || mem_write_data !== 32'h0)
         $display("FAIL reset_cmd: got addr %h wdata %h, want 0 0", mem_address, mem_write_data);
      else passed++;
      checks++;
      if (cpu_rdata !== 32'h0 || dbg_rdata !== 32'h0)
         $display("FAIL reset_rdata: got %h %h, want 0 0", cpu_rdata, dbg_rdata);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single_read();
      @(posedge clk); #1;
      drive_port(CPU, 1'b1, 1'b0, 7'h05, 32'h0);
      expect_txn(CPU, 1'b0, 7'h05, 32'h0);
      @(negedge clk);
      checks++;
      if (cpu_stall !== 1'b1 || mem_read !== 1'b0)
         $display("FAIL read_cycle_k: got stall %b read %b, want 1 0", cpu_stall, mem_read);
      else passed++;
      @(negedge clk);
      checks++;
      if (mem_read !== 1'b1 || mem_address !== 7'h05 || cpu_stall !== 1'b1)
         $display("FAIL read_cycle_k1: got read %b addr %h stall %b, want 1 05 1",
                  mem_read, mem_address, cpu_stall);
      else passed++;
      @(negedge clk);
      checks++;
      if (cpu_ack !== 1'b1 || cpu_rdata !== 32'hDEADBEEF || cpu_stall !== 1'b0)
         $display("FAIL read_cycle_k2: got ack %b rdata %h stall %b, want 1 deadbeef 0",
                  cpu_ack, cpu_rdata, cpu_stall);
      else passed++;
      cpu_req = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (cpu_ack !== 1'b0 || cpu_rdata !== 32'hDEADBEEF)
         $display("FAIL read_hold: got ack %b rdata %h, want 0 deadbeef", cpu_ack, cpu_rdata);
      else passed++;
   endtask

   task automatic test_write_readback();
      int lat, strobes;
      do_access(CPU, 1'b1, 7'h10, 32'h12345678, lat, strobes);
      checks++;
      if (strobes !== 1 || lat !== 3)
         $display("FAIL write_strobe: got strobes %0d latency %0d, want 1 3", strobes, lat);
      else passed++;
      checks++;
      if (cpu_rdata !== 32'hDEADBEEF)
         $display("FAIL write_rdata_kept: got %h, want deadbeef", cpu_rdata);
      else passed++;
      do_access(CPU, 1'b0, 7'h10, 32'h0, lat, strobes);
      checks++;
      if (cpu_rdata !== 32'h12345678)
         $display("FAIL readback: got %h, want 12345678", cpu_rdata);
      else passed++;
   endtask

   task automatic test_simultaneous();
      int  ack_cyc [4];
      bit  ack_port [4];
      int  n = 0;
      apply_reset();
      drive_port(CPU, 1'b1, 1'b0, 7'h01, 32'h0);
      drive_port(DBG, 1'b1, 1'b0, 7'h02, 32'h0);
      expect_txn(CPU, 1'b0, 7'h01, 32'h0);
      expect_txn(DBG, 1'b0, 7'h02, 32'h0);
      expect_txn(CPU, 1'b0, 7'h01, 32'h0);
      expect_txn(DBG, 1'b0, 7'h02, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 40 && n < 4; c++) begin
         @(negedge clk);
         if (cpu_ack || dbg_ack) begin
            ack_cyc[n]  = c;
            ack_port[n] = dbg_ack;
            n++;
         end
      end
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      checks++;
      if (n != 4) $display("FAIL rr_timeout: got %0d acks, want 4", n);
      else passed++;
      for (int i = 0; i < n; i++) begin
         checks++;
         if (ack_port[i] !== ((i % 2) == 1))
            $display("FAIL rr_order: ack %0d got port %b, want %b", i, ack_port[i], (i % 2) == 1);
         else passed++;
         if (i > 0) begin
            checks++;
            if (ack_cyc[i] - ack_cyc[i-1] != 3)
               $display("FAIL rr_spacing: ack %0d got gap %0d, want 3", i,
                        ack_cyc[i] - ack_cyc[i-1]);
            else passed++;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_op();
      bit hit = 0;
      int lat, strobes;
      @(posedge clk); #1;
      drive_port(CPU, 1'b1, 1'b0, 7'h05, 32'h0);
      expect_txn(CPU, 1'b0, 7'h05, 32'h0);
      for (int i = 0; i < 6 && !hit; i++) begin
         @(negedge clk);
         if (mem_read) hit = 1;
      end
      checks++;
      if (!hit) $display("FAIL midrst_access: got no strobe, want strobe");
      else passed++;
      apply_reset();
      #1;
      checks++;
      if ({mem_read, mem_write, cpu_ack, dbg_ack} !== 4'b0 || mem_address !== 7'h0 ||
          mem_write_data !== 32'h0 || cpu_rdata !== 32'h0 || dbg_rdata !== 32'h0)
         $display("FAIL midrst_values: got ctl %b addr %h wd %h rd %h %h, want all 0",
                  {mem_read, mem_write, cpu_ack, dbg_ack}, mem_address, mem_write_data,
                  cpu_rdata, dbg_rdata);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      do_access(DBG, 1'b0, 7'h02, 32'h0, lat, strobes);
      checks++;
      if (dbg_rdata !== 32'h22220002 || cpu_rdata !== 32'h0 || lat !== 3)
         $display("FAIL midrst_fresh: got dbg %h cpu %h lat %0d, want 22220002 0 3",
                  dbg_rdata, cpu_rdata, lat);
      else passed++;
   endtask

   task automatic test_withdrawn();
      int  events = 0;
      bit  hit = 0;
      bit  got = 0;
      @(posedge clk); #1;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 7'h01;
      @(negedge clk);
      dbg_req = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (mem_read || mem_write || cpu_ack || dbg_ack) events++;
      end
      checks++;
      if (events != 0) $display("FAIL withdrawn_idle: got %0d events, want 0", events);
      else passed++;
      @(posedge clk); #1;
      drive_port(DBG, 1'b1, 1'b0, 7'h01, 32'h0);
      expect_txn(DBG, 1'b0, 7'h01, 32'h0);
      for (int i = 0; i < 6 && !hit; i++) begin
         @(negedge clk);
         if (mem_read) hit = 1;
      end
      dbg_req = 1'b0;
      for (int i = 0; i < 6 && !got; i++) begin
         @(negedge clk);
         if (dbg_ack) got = 1;
      end
      checks++;
      if (!hit || !got)
         $display("FAIL dropped_after_grant: got strobe %b ack %b, want 1 1", hit, got);
      else passed++;
   endtask

   initial begin
      for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i[6:0]);
      test_reset();
      test_single_read();
      test_write_readback();
      test_simultaneous();
      test_reset_mid_op();
      test_withdrawn();
      repeat (4) @(negedge clk);
      checks++;
      if (ack_q.size() != 0 || cmd_q.size() != 0)
         $display("FAIL scoreboard_drain: got %0d acks %0d cmds pending, want 0 0",
                  ack_q.size(), cmd_q.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
